// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes
// and the datapath select codes driven by the controller.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_READ, ST_MEM_WB, ST_MEM_WRITE,
    ST_EXEC_R, ST_EXEC_I, ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR,
    ST_JALR_LINK, ST_LUI, ST_ERROR
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
    ALU_SLT = 3'b100, ALU_SLTU = 3'b101, ALU_XOR = 3'b110
  } alu_cntl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10, RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRC_A_PC = 2'b00, SRC_A_OLD_PC = 2'b01, SRC_A_RS1 = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10
  } src_b_e;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_wait_state(state_e s);
    return s inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE};
  endfunction

endpackage

// File: rtl/riscv_multi_cycle_controller_if.sv
// Memory handshake between the multi-cycle controller (master) and the
// shared instruction/data memory (slave).
interface riscv_multi_cycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/riscv_mc_alu_decoder.sv
// Combinational instruction decoder: ALU operation, immediate format and a
// legality flag derived from opc/func3/func7.
module riscv_mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] opc,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_cntl,
  output logic [2:0] imm_src,
  output logic       legal
);

  alu_cntl_e arith_op;
  logic      arith_ok;

  always_comb begin
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (func3)
      3'b000:  arith_op = ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_cntl = ALU_ADD;
    imm_src  = IMM_I;
    legal    = 1'b0;
    case (opc)
      OPC_LOAD:   legal = 1'b1;
      OPC_STORE:  begin imm_src = IMM_S; legal = 1'b1; end
      OPC_OP: begin
        // func7[5] selects sub only for func3 000; it is ignored for the logic ops.
        alu_cntl = (func3 == 3'b000 && func7[5]) ? ALU_SUB : arith_op;
        legal    = arith_ok && (func7 == 7'b0000000 || func7 == 7'b0100000);
      end
      OPC_OP_IMM: begin alu_cntl = arith_op; legal = arith_ok; end
      OPC_BRANCH: begin
        alu_cntl = ALU_SUB;
        imm_src  = IMM_B;
        legal    = func3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
      end
      OPC_JAL:    begin imm_src = IMM_J; legal = 1'b1; end
      OPC_JALR:   legal = 1'b1;
      OPC_LUI:    begin imm_src = IMM_U; legal = 1'b1; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_multi_cycle_controller.sv
// Moore-FSM control unit for the shared-memory RV32I multi-cycle datapath.
// Optional performance counters are built when RISCV_MC_PERF_CNT_EN is defined.
module riscv_multi_cycle_controller
  import riscv_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
`ifdef RISCV_MC_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opc,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       pos,
  riscv_multi_cycle_controller_if.master mem,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_cntl,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       error
`ifdef RISCV_MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state, state_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit, branch_taken;
  logic             mem_req_s, mem_write_s, adr_src_s;
  logic [2:0]       dec_alu_cntl, dec_imm_src;
  logic             dec_legal;

  riscv_mc_alu_decoder u_alu_decoder (
    .opc      (opc),
    .func3    (func3),
    .func7    (func7),
    .alu_cntl (dec_alu_cntl),
    .imm_src  (dec_imm_src),
    .legal    (dec_legal)
  );

  // A ready in the firing cycle wins: the access completes instead of faulting.
  assign tmo_hit = (MEM_TIMEOUT != 0) && !mem.mem_ready && (tmo_cnt == TMO_LAST);

  always_comb begin
    case (func3)
      F3_BEQ:  branch_taken = zero;
      F3_BNE:  branch_taken = !zero;
      F3_BLT:  branch_taken = !pos;
      F3_BGE:  branch_taken = pos;
      default: branch_taken = 1'b0;
    endcase
  end

  // NOTE: async reset with non-blocking updates keeps every register sampling the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        tmo_cnt <= '0;
      else if (is_wait_state(state) && !mem.mem_ready)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output and the next state get a default first so no path infers a latch.
    state_next  = state;
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    adr_src_s   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_cntl    = ALU_ADD;
    result_src  = RES_ALU_OUT;
    imm_src     = IMM_I;
    error       = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (tmo_hit) begin
          state_next = ST_ERROR;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = dec_imm_src;
        if (!dec_legal) state_next = ST_ERROR;
        else begin
          case (opc)
            OPC_LOAD, OPC_STORE: state_next = ST_MEM_ADR;
            OPC_OP:              state_next = ST_EXEC_R;
            OPC_OP_IMM:          state_next = ST_EXEC_I;
            OPC_BRANCH:          state_next = ST_BRANCH;
            OPC_JAL:             state_next = ST_JAL;
            OPC_JALR:            state_next = ST_JALR;
            OPC_LUI:             state_next = ST_LUI;
            default:             state_next = ST_ERROR;
          endcase
        end
      end
      ST_MEM_ADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        imm_src    = dec_imm_src;
        state_next = (opc == OPC_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem.mem_ready) state_next = ST_MEM_WB;
        else if (tmo_hit)  state_next = ST_ERROR;
      end
      ST_MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (mem.mem_ready) state_next = ST_FETCH;
        else if (tmo_hit)  state_next = ST_ERROR;
      end
      ST_EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_cntl   = dec_alu_cntl;
        state_next = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_cntl   = dec_alu_cntl;
        imm_src    = dec_imm_src;
        state_next = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_cntl   = ALU_SUB;
        pc_write   = branch_taken;
        state_next = ST_FETCH;
      end
      ST_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        state_next = ST_ALU_WB;
      end
      ST_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        imm_src    = dec_imm_src;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_next = ST_JALR_LINK;
      end
      ST_JALR_LINK: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_ERROR: error = 1'b1;
      default:  state_next = ST_ERROR;
    endcase
    // Outputs are forced low for the whole reset pulse, including mid-access.
    if (rst) begin
      mem_req_s   = 1'b0;
      mem_write_s = 1'b0;
      adr_src_s   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = '0;
      alu_src_b   = '0;
      alu_cntl    = '0;
      result_src  = '0;
      imm_src     = '0;
      error       = 1'b0;
    end
  end

  assign mem.mem_req   = mem_req_s;
  assign mem.mem_write = mem_write_s;
  assign mem.adr_src   = adr_src_s;

`ifdef RISCV_MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_ERROR)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (state_next == ST_FETCH && state != ST_FETCH)
        instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_multi_cycle_controller.sv
// Directed self-checking bench for riscv_multi_cycle_controller; outputs are
// packed into one vector and compared against hand-built per-state values.
module tb_riscv_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, pos;
  logic       ir_write, pc_write, reg_write, error;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_cntl, imm_src;
  int         checks = 0;
  int         failures = 0;

  riscv_multi_cycle_controller_if bus ();

  riscv_multi_cycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opc        (opc),
    .func3      (func3),
    .func7      (func7),
    .zero       (zero),
    .pos        (pos),
    .mem        (bus),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_cntl   (alu_cntl),
    .result_src (result_src),
    .imm_src    (imm_src),
    .error      (error)
  );

  always #5 clk = ~clk;

  // {req, wr, adr, ir, pc, rw, src_a, src_b, alu, res, imm, err}
  function automatic logic [18:0] sig(input logic req, wr, adr, ir, pc, rw,
                                      input logic [1:0] a, b, input logic [2:0] alu,
                                      input logic [1:0] res, input logic [2:0] imm,
                                      input logic err);
    return {req, wr, adr, ir, pc, rw, a, b, alu, res, imm, err};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.mem_req, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_cntl, result_src, imm_src, error};
  endfunction

  localparam logic [18:0] F_WAIT = sig(1,0,0,0,0,0, 2'b00,2'b10,3'b000,2'b10,3'b000,0);
  localparam logic [18:0] F_GO   = sig(1,0,0,1,1,0, 2'b00,2'b10,3'b000,2'b10,3'b000,0);
  localparam logic [18:0] D_I    = sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] EX_ADD = sig(0,0,0,0,0,0, 2'b10,2'b00,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] WB_ALU = sig(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] M_ADR  = sig(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] M_RD   = sig(1,0,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] M_WB   = sig(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b01,3'b000,0);
  localparam logic [18:0] M_WR   = sig(1,1,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'b000,0);
  localparam logic [18:0] ERR    = sig(0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'b000,1);
  localparam logic [18:0] IDLE   = 19'h0;

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opc = o; func3 = f3; func7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    if (obs() !== IDLE) begin
      $display("FAIL reset_hold got=%h exp=%h", obs(), IDLE); failures++;
    end
    checks++;
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    if (obs() !== F_WAIT) begin
      $display("FAIL reset_release got=%h exp=%h", obs(), F_WAIT); failures++;
    end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [18:0] exp_v [4];
    exp_v = '{F_GO, D_I, EX_ADD, WB_ALU};
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1; #1;
      if (obs() !== exp_v[i]) begin
        $display("FAIL add cyc%0d got=%h exp=%h", i, obs(), exp_v[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0]  t_opc [7];
    logic [2:0]  t_f3  [7];
    logic [6:0]  t_f7  [7];
    logic [18:0] t_ex  [7];
    logic [18:0] exp_v [4];
    t_opc = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
    t_f3  = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b011, 3'b100, 3'b000};
    t_f7  = '{7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0100000};
    t_ex  = '{sig(0,0,0,0,0,0, 2'b10,2'b00,3'b001,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b00,3'b010,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b00,3'b011,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b00,3'b100,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b00,3'b101,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b00,3'b110,2'b00,3'b000,0),
              sig(0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,3'b000,0)};
    for (int r = 0; r < 7; r++) begin
      set_instr(t_opc[r], t_f3[r], t_f7[r]);
      exp_v = '{F_GO, D_I, t_ex[r], WB_ALU};
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = 1'b1; #1;
        if (obs() !== exp_v[i]) begin
          $display("FAIL alu_op row%0d cyc%0d got=%h exp=%h", r, i, obs(), exp_v[i]); failures++;
        end
        checks++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_timeout();
    logic [18:0] expd;
    // Ready arriving on the 16th wait cycle completes the fetch.
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 19; i++) begin
      bus.mem_ready = (i >= 15);
      expd = (i < 15) ? F_WAIT : (i == 15) ? F_GO : (i == 16) ? D_I : (i == 17) ? EX_ADD : WB_ALU;
      #1;
      if (obs() !== expd) begin
        $display("FAIL tmo_edge cyc%0d got=%h exp=%h", i, obs(), expd); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
    // Ready never arrives: 16 wait cycles, then a sticky ERROR that ignores ready.
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = (i >= 18);
      expd = (i < 16) ? F_WAIT : ERR;
      #1;
      if (obs() !== expd) begin
        $display("FAIL tmo_fire cyc%0d got=%h exp=%h", i, obs(), expd); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
    do_reset();
    bus.mem_ready = 1'b0; #1;
    if (obs() !== F_WAIT) begin
      $display("FAIL tmo_recover got=%h exp=%h", obs(), F_WAIT); failures++;
    end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_wait();
    logic [18:0] exp_v [11];
    logic        rdy   [11];
    exp_v = '{F_WAIT, F_WAIT, F_WAIT, F_GO, D_I, M_ADR, M_RD, M_RD, M_RD, M_RD, M_WB};
    rdy   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    for (int i = 0; i < 11; i++) begin
      bus.mem_ready = rdy[i]; #1;
      if (obs() !== exp_v[i]) begin
        $display("FAIL lw cyc%0d got=%h exp=%h", i, obs(), exp_v[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [18:0] exp_v [5];
    logic [18:0] msk   [5];
    logic        rdy   [5];
    exp_v = '{F_GO, sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,3'b001,0), M_ADR, M_WR, M_WR};
    msk   = '{19'h7FFFF, 19'h7FFFF, 19'h7FFF1, 19'h7FFFF, 19'h7FFFF};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i]; #1;
      if ((obs() & msk[i]) !== (exp_v[i] & msk[i])) begin
        $display("FAIL sw cyc%0d got=%h exp=%h", i, obs() & msk[i], exp_v[i] & msk[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [2:0]  t_f3  [5];
    logic        t_z   [5];
    logic        t_p   [5];
    logic        t_tk  [5];
    logic [18:0] exp_v [3];
    t_f3 = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101};
    t_z  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_p  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t_tk = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int r = 0; r < 5; r++) begin
      set_instr(7'b1100011, t_f3[r], 7'b0000000);
      zero = t_z[r]; pos = t_p[r];
      exp_v = '{F_GO, sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,3'b010,0),
                sig(0,0,0,0,t_tk[r],0, 2'b10,2'b00,3'b001,2'b00,3'b000,0)};
      for (int i = 0; i < 3; i++) begin
        bus.mem_ready = 1'b1; #1;
        if (obs() !== exp_v[i]) begin
          $display("FAIL branch row%0d cyc%0d got=%h exp=%h", r, i, obs(), exp_v[i]); failures++;
        end
        checks++;
        @(posedge clk); #1;
      end
    end
    zero = 1'b0; pos = 1'b0;
  endtask

  task automatic test_jal_lui();
    logic [18:0] exp_v [7];
    logic [6:0]  t_opc [7];
    exp_v = '{F_GO, sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,3'b011,0),
              sig(0,0,0,0,1,0, 2'b01,2'b10,3'b000,2'b00,3'b000,0), WB_ALU,
              F_GO, sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,3'b100,0),
              sig(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b11,3'b100,0)};
    t_opc = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b0110111, 7'b0110111, 7'b0110111};
    for (int i = 0; i < 7; i++) begin
      set_instr(t_opc[i], 3'b000, 7'b0000000);
      bus.mem_ready = 1'b1; #1;
      if (obs() !== exp_v[i]) begin
        $display("FAIL jal_lui cyc%0d got=%h exp=%h", i, obs(), exp_v[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [6:0]  t_opc [4];
    logic [2:0]  t_f3  [4];
    logic [6:0]  t_f7  [4];
    logic [2:0]  t_imm [4];
    logic [18:0] exp_v [4];
    t_opc = '{7'b1111111, 7'b0110011, 7'b0110011, 7'b1100011};
    t_f3  = '{3'b000, 3'b001, 3'b000, 3'b010};
    t_f7  = '{7'b0000000, 7'b0000001, 7'b0000001, 7'b0000000};
    t_imm = '{3'b000, 3'b000, 3'b000, 3'b010};
    for (int r = 0; r < 4; r++) begin
      set_instr(t_opc[r], t_f3[r], t_f7[r]);
      exp_v = '{F_GO, sig(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,t_imm[r],0), ERR, ERR};
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = 1'b1; #1;
        if (obs() !== exp_v[i]) begin
          $display("FAIL illegal row%0d cyc%0d got=%h exp=%h", r, i, obs(), exp_v[i]); failures++;
        end
        checks++;
        @(posedge clk); #1;
      end
      do_reset();
    end
  endtask

  task automatic test_jalr_reset();
    logic [18:0] exp_v [4];
    localparam logic [18:0] JALR_S = sig(0,0,0,0,1,0, 2'b10,2'b01,3'b000,2'b10,3'b000,0);
    exp_v = '{F_GO, D_I, JALR_S, sig(0,0,0,0,0,1, 2'b01,2'b10,3'b000,2'b10,3'b000,0)};
    set_instr(7'b1100111, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1; #1;
      if (obs() !== exp_v[i]) begin
        $display("FAIL jalr cyc%0d got=%h exp=%h", i, obs(), exp_v[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'b1; #1;
      if (obs() !== exp_v[i]) begin
        $display("FAIL jalr2 cyc%0d got=%h exp=%h", i, obs(), exp_v[i]); failures++;
      end
      checks++;
      @(posedge clk); #1;
    end
    #1;
    if (obs() !== JALR_S) begin
      $display("FAIL jalr2_state got=%h exp=%h", obs(), JALR_S); failures++;
    end
    checks++;
    rst = 1'b1; #1;
    if (obs() !== IDLE) begin
      $display("FAIL jalr_rst_hold got=%h exp=%h", obs(), IDLE); failures++;
    end
    checks++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b0; #1;
    if (obs() !== F_WAIT) begin
      $display("FAIL jalr_rst_fetch got=%h exp=%h", obs(), F_WAIT); failures++;
    end
    checks++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    zero = 1'b0;
    pos = 1'b0;
    set_instr(7'b0000000, 3'b000, 7'b0000000);
    test_reset();
    test_add();
    test_alu_ops();
    test_timeout();
    test_load_wait();
    test_store();
    test_branch();
    test_jal_lui();
    test_illegal();
    test_jalr_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_multi_cycle_controller.md
Name: riscv_multi_cycle_controller

Overview:
- Multi-cycle control unit for the RV32I subset core; the next generation after the single-cycle controller.
- Drives a shared-memory datapath (one memory for instruction and data) through a Moore FSM.
- Adds a memory request/ready handshake, a configurable wait timeout, and a sticky illegal-instruction error state.
- Sits beside the multi-cycle datapath under the core top.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready before entering ERROR. 0 disables the timeout.
- TMO_W, 8: width of the timeout counter. Must hold MEM_TIMEOUT.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- opc  in  7  instruction[6:0] from the instruction register
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- zero  in  1  ALU result == 0
- pos  in  1  ALU result MSB == 0
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a store (valid only with mem_req)
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  load PC from result
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- alu_cntl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sltu, 110 xor
- result_src  out  2  result select: 00 = alu_out register, 01 = data register, 10 = ALU combinational output, 11 = imm
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- error  out  1  sticky fault flag

Behaviour:
- Reset: state = FETCH, timeout counter = 0, error = 0. While rst is high every strobe (mem_req, mem_write, ir_write, pc_write, reg_write) is 0 and every select output is 0.
- Selects are Moore functions of state. pc_write and ir_write in wait states are additionally qualified by mem_ready. Any select not listed for a state is 0.
- FETCH: mem_req = 1, adr_src = 0, A = PC, B = 4, add, result_src = 10. On mem_ready: ir_write = 1, pc_write = 1, go to DECODE. Otherwise stay.
- DECODE: A = old_pc, B = imm, add (alu_out becomes the branch/JAL target). imm_src follows opc. Next state by opc:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode, or an illegal func3/func7 for the opcode -> ERROR
- MEM_ADR: A = rs1, B = imm, add. Next MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_req = 1, adr_src = 1, result_src = 00. On mem_ready go to MEM_WB.
- MEM_WB: result_src = 01, reg_write = 1, then FETCH.
- MEM_WRITE: mem_req = 1, mem_write = 1, adr_src = 1, result_src = 00. On mem_ready go to FETCH.
- EXEC_R: A = rs1, B = rs2. alu_cntl decoded as:
  - func3 000: add when func7[5] = 0, sub when func7[5] = 1
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu
  - any other func3, or any func7 other than 0000000/0100000 -> ERROR from DECODE
- EXEC_I: A = rs1, B = imm. Same func3 mapping, always add for 000. Then ALU_WB.
- ALU_WB: result_src = 00, reg_write = 1, then FETCH.
- BRANCH: A = rs1, B = rs2, sub, result_src = 00. pc_write = taken:
  - beq: zero
  - bne: !zero
  - blt: !pos
  - bge: pos
  - signed overflow is ignored (accepted simplification)
  - other func3 -> ERROR from DECODE
  - then FETCH
- JAL: A = old_pc, B = 4, add, result_src = 00, pc_write = 1. Then ALU_WB, which writes old_pc + 4 to rd.
- JALR: A = rs1, B = imm, add, result_src = 10, pc_write = 1. Then JALR_LINK.
- JALR_LINK: A = old_pc, B = 4, add, result_src = 10, reg_write = 1, then FETCH. rs1 is read before rd is written, so rd == rs1 is safe.
- LUI: imm_src = U, result_src = 11, reg_write = 1, then FETCH.
- Timeout: the counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle that mem_ready is low. When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, go to ERROR.
- mem_ready high in the same cycle the timeout would fire: the access completes and ERROR is not entered.
- ERROR: error = 1, all strobes 0. The state is held until rst.
- mem_ready outside a wait state is ignored.
- Reset asserted mid-access drops mem_req asynchronously.

Optional Feature:
- Macro: RISCV_MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt and instret_cnt, each CNT_W bits wide, reset to 0.
  - cycle_cnt increments every cycle not in ERROR.
  - instret_cnt increments on every transition into FETCH from a non-FETCH state.
  - both wrap modulo 2^CNT_W
- Undefined: neither port nor its logic exists.

Decomposition:
- Package riscv_mc_pkg holds:
  - the state encoding constants
  - the opcode constants
  - the alu_cntl, imm_src, result_src, alu_src_a and alu_src_b codes
- One sub-module, riscv_mc_alu_decoder: combinational; maps opc/func3/func7 to alu_cntl, imm_src and a legal flag.

Test Plan:
- add x3,x1,x2 with mem_ready high on the request cycle -> FETCH, DECODE, EXEC_R, ALU_WB, FETCH; 4 cycles; reg_write for exactly 1 cycle; alu_cntl = 000.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_READ -> mem_req held for 4 cycles in each; ir_write pulses once; reg_write in MEM_WB with result_src = 01.
- beq with zero = 1, then beq with zero = 0 -> pc_write asserted in BRANCH only in the first case; alu_cntl = 001.
- MEM_TIMEOUT = 16, mem_ready held low -> ERROR entered on the 16th wait cycle; error = 1; mem_req = 0; the state persists until rst.
- Opcode 1111111, then func3 = 001 on opcode 0110011 with func7 = 0000001 -> both reach ERROR from DECODE.
- jalr x1,0(x1) -> JALR pc_write with result_src = 10, then JALR_LINK reg_write; rst pulsed in the JALR cycle returns to FETCH with all strobes 0.
